// File: rtl/cpl_arb_pkg.sv
// cpl_arb_pkg: shared types for the completion TLP transmit arbiter.
//   arb_state_e : arbiter FSM states (IDLE, LOCK0, LOCK1)
//   SRC_AXI/MCTP: source indices (0 = AXI read-completion, 1 = MCTP responses)
//   tlp_beat_t  : one TLP beat at the default widths
package cpl_arb_pkg;

  localparam int CPL_DATA_W = 256;
  localparam int CPL_STRB_W = CPL_DATA_W / 32;
  localparam int CPL_HDR_W  = 128;

  localparam logic SRC_AXI  = 1'b0;
  localparam logic SRC_MCTP = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [CPL_DATA_W-1:0] data;
    logic [CPL_STRB_W-1:0] strb;
    logic [CPL_HDR_W-1:0]  hdr;
    logic                  sop;
    logic                  eop;
  } tlp_beat_t;

endpackage

// File: rtl/cpl_tlp_tx_arbiter_tlp_pipe_reg.sv
// tlp_pipe_reg: single-entry valid/ready register for one TLP beat.
//   clk, rst      : clock, synchronous active-high reset
//   i_valid/i_beat: beat to load (loaded only when o_slot_free)
//   o_slot_free   : register is empty or draining this cycle
//   o_valid/o_beat: registered beat toward the sink, stable while stalled
//   i_ready       : sink accepts o_beat
module tlp_pipe_reg
  import cpl_arb_pkg::*;
#(
  parameter type T = tlp_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  input  T     i_beat,
  output logic o_slot_free,
  output logic o_valid,
  output T     o_beat,
  input  logic i_ready
);

  logic r_valid;
  T     r_beat;

  assign o_slot_free = !r_valid || i_ready;
  assign o_valid     = r_valid;
  assign o_beat      = r_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_beat  <= '0;
    end else if (o_slot_free) begin
      r_valid <= i_valid;
      // Payload only moves on a real load; an emptied slot keeps the last
      // beat, which is harmless because valid is low.
      if (i_valid) r_beat <= i_beat;
    end
  end

endmodule

// File: rtl/cpl_tlp_tx_arbiter.sv
// cpl_tlp_tx_arbiter: round-robin, packet-granular arbiter sharing the
// completion TLP TX port between the AXI read-completion generator (s0)
// and the CXL.io MCTP response engine (s1), with one registered output stage.
//   clk, rst                 : clock, synchronous active-high reset
//   s0_tlp_* / s1_tlp_*      : source beat streams (data/strb/hdr/valid/sop/eop, ready out)
//   tx_cpl_tlp_*             : arbitrated registered stream (ready in)
//   grant_id                 : source holding a multi-beat lock
//   proto_err                : 1-cycle pulse when a non-SOP beat is dropped in IDLE
//   pkt_cnt0 / pkt_cnt1      : completed-TLP counters, wrap mod 2^16
module cpl_tlp_tx_arbiter
  import cpl_arb_pkg::*;
#(
  parameter int TLP_DATA_WIDTH = 256,
  parameter int TLP_STRB_WIDTH = 8,
  parameter int TLP_HDR_WIDTH  = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TLP_DATA_WIDTH-1:0] s0_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0] s0_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]  s0_tlp_hdr,
  input  logic                      s0_tlp_valid,
  input  logic                      s0_tlp_sop,
  input  logic                      s0_tlp_eop,
  output logic                      s0_tlp_ready,
  input  logic [TLP_DATA_WIDTH-1:0] s1_tlp_data,
  input  logic [TLP_STRB_WIDTH-1:0] s1_tlp_strb,
  input  logic [TLP_HDR_WIDTH-1:0]  s1_tlp_hdr,
  input  logic                      s1_tlp_valid,
  input  logic                      s1_tlp_sop,
  input  logic                      s1_tlp_eop,
  output logic                      s1_tlp_ready,
  output logic [TLP_DATA_WIDTH-1:0] tx_cpl_tlp_data,
  output logic [TLP_STRB_WIDTH-1:0] tx_cpl_tlp_strb,
  output logic [TLP_HDR_WIDTH-1:0]  tx_cpl_tlp_hdr,
  output logic                      tx_cpl_tlp_valid,
  output logic                      tx_cpl_tlp_sop,
  output logic                      tx_cpl_tlp_eop,
  input  logic                      tx_cpl_tlp_ready,
  output logic                      grant_id,
  output logic                      proto_err,
  output logic [15:0]               pkt_cnt0,
  output logic [15:0]               pkt_cnt1
);

  // Beat layout at this instance's widths; same field order as tlp_beat_t.
  typedef struct packed {
    logic [TLP_DATA_WIDTH-1:0] data;
    logic [TLP_STRB_WIDTH-1:0] strb;
    logic [TLP_HDR_WIDTH-1:0]  hdr;
    logic                      sop;
    logic                      eop;
  } beat_t;

  arb_state_e  r_state;
  logic        r_rr_ptr;
  logic        r_grant_id;
  logic        r_proto_err;
  logic [15:0] r_cnt0;
  logic [15:0] r_cnt1;

  logic  w_free;
  logic  w_idle;
  logic  w_err0, w_err1;
  logic  w_elig0, w_elig1;
  logic  w_win0, w_win1;
  logic  w_rdy0, w_rdy1;
  logic  w_fwd0, w_fwd1;
  beat_t w_in_beat;
  beat_t w_out_beat;

  assign w_idle  = (r_state == IDLE);

  // IDLE: a valid beat without SOP is a protocol error and gets drained;
  // a valid SOP beat competes for the port.
  assign w_err0  = s0_tlp_valid && !s0_tlp_sop;
  assign w_err1  = s1_tlp_valid && !s1_tlp_sop;
  assign w_elig0 = s0_tlp_valid && s0_tlp_sop;
  assign w_elig1 = s1_tlp_valid && s1_tlp_sop;
  assign w_win0  = w_elig0 && (!w_elig1 || (r_rr_ptr == SRC_AXI));
  assign w_win1  = w_elig1 && (!w_elig0 || (r_rr_ptr == SRC_MCTP));

  always_comb begin
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    case (r_state)
      IDLE: begin
        w_rdy0 = w_err0 || w_win0;
        w_rdy1 = w_err1 || w_win1;
      end
      LOCK0:   w_rdy0 = 1'b1;
      LOCK1:   w_rdy1 = 1'b1;
      default: ;
    endcase
  end

  // Nothing is accepted while reset is asserted.
  assign s0_tlp_ready = !rst && w_free && w_rdy0;
  assign s1_tlp_ready = !rst && w_free && w_rdy1;

  // Accepted beats that go downstream; drained error beats do not.
  assign w_fwd0 = s0_tlp_valid && s0_tlp_ready && !(w_idle && !s0_tlp_sop);
  assign w_fwd1 = s1_tlp_valid && s1_tlp_ready && !(w_idle && !s1_tlp_sop);

  always_comb begin
    w_in_beat = '0;
    if (w_fwd1) begin
      w_in_beat.data = s1_tlp_data;
      w_in_beat.strb = s1_tlp_strb;
      w_in_beat.hdr  = s1_tlp_hdr;
      w_in_beat.sop  = s1_tlp_sop;
      w_in_beat.eop  = s1_tlp_eop;
    end else begin
      w_in_beat.data = s0_tlp_data;
      w_in_beat.strb = s0_tlp_strb;
      w_in_beat.hdr  = s0_tlp_hdr;
      w_in_beat.sop  = s0_tlp_sop;
      w_in_beat.eop  = s0_tlp_eop;
    end
  end

  tlp_pipe_reg #(.T(beat_t)) u_pipe (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (w_fwd0 || w_fwd1),
    .i_beat     (w_in_beat),
    .o_slot_free(w_free),
    .o_valid    (tx_cpl_tlp_valid),
    .o_beat     (w_out_beat),
    .i_ready    (tx_cpl_tlp_ready)
  );

  assign tx_cpl_tlp_data = w_out_beat.data;
  assign tx_cpl_tlp_strb = w_out_beat.strb;
  assign tx_cpl_tlp_hdr  = w_out_beat.hdr;
  assign tx_cpl_tlp_sop  = w_out_beat.sop;
  assign tx_cpl_tlp_eop  = w_out_beat.eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= SRC_AXI;
      r_grant_id  <= SRC_AXI;
      r_proto_err <= 1'b0;
      r_cnt0      <= '0;
      r_cnt1      <= '0;
    end else begin
      // One pulse even when both sources are dropped together.
      r_proto_err <= w_idle && w_free && (w_err0 || w_err1);
      case (r_state)
        IDLE: begin
          if (w_fwd0) begin
            if (s0_tlp_eop) begin
              r_rr_ptr <= SRC_MCTP;
              r_cnt0   <= r_cnt0 + 16'd1;
            end else begin
              r_state    <= LOCK0;
              r_grant_id <= SRC_AXI;
            end
          end else if (w_fwd1) begin
            if (s1_tlp_eop) begin
              r_rr_ptr <= SRC_AXI;
              r_cnt1   <= r_cnt1 + 16'd1;
            end else begin
              r_state    <= LOCK1;
              r_grant_id <= SRC_MCTP;
            end
          end
        end
        LOCK0: begin
          if (w_fwd0 && s0_tlp_eop) begin
            r_state  <= IDLE;
            r_rr_ptr <= SRC_MCTP;
            r_cnt0   <= r_cnt0 + 16'd1;
          end
        end
        LOCK1: begin
          if (w_fwd1 && s1_tlp_eop) begin
            r_state  <= IDLE;
            r_rr_ptr <= SRC_AXI;
            r_cnt1   <= r_cnt1 + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant_id  = r_grant_id;
  assign proto_err = r_proto_err;
  assign pkt_cnt0  = r_cnt0;
  assign pkt_cnt1  = r_cnt1;

endmodule

// File: tb/tb_cpl_tlp_tx_arbiter.sv
module tb_cpl_tlp_tx_arbiter;

  logic         clk;
  logic         rst;
  logic [255:0] s0_tlp_data, s1_tlp_data;
  logic [7:0]   s0_tlp_strb, s1_tlp_strb;
  logic [127:0] s0_tlp_hdr, s1_tlp_hdr;
  logic         s0_tlp_valid, s0_tlp_sop, s0_tlp_eop, s0_tlp_ready;
  logic         s1_tlp_valid, s1_tlp_sop, s1_tlp_eop, s1_tlp_ready;
  logic [255:0] tx_cpl_tlp_data;
  logic [7:0]   tx_cpl_tlp_strb;
  logic [127:0] tx_cpl_tlp_hdr;
  logic         tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_ready;
  logic         grant_id, proto_err;
  logic [15:0]  pkt_cnt0, pkt_cnt1;

  int passed = 0;
  int total  = 0;

  cpl_tlp_tx_arbiter #(.TLP_DATA_WIDTH(256), .TLP_STRB_WIDTH(8), .TLP_HDR_WIDTH(128)) dut (
    .clk(clk), .rst(rst),
    .s0_tlp_data(s0_tlp_data), .s0_tlp_strb(s0_tlp_strb), .s0_tlp_hdr(s0_tlp_hdr),
    .s0_tlp_valid(s0_tlp_valid), .s0_tlp_sop(s0_tlp_sop), .s0_tlp_eop(s0_tlp_eop),
    .s0_tlp_ready(s0_tlp_ready),
    .s1_tlp_data(s1_tlp_data), .s1_tlp_strb(s1_tlp_strb), .s1_tlp_hdr(s1_tlp_hdr),
    .s1_tlp_valid(s1_tlp_valid), .s1_tlp_sop(s1_tlp_sop), .s1_tlp_eop(s1_tlp_eop),
    .s1_tlp_ready(s1_tlp_ready),
    .tx_cpl_tlp_data(tx_cpl_tlp_data), .tx_cpl_tlp_strb(tx_cpl_tlp_strb),
    .tx_cpl_tlp_hdr(tx_cpl_tlp_hdr), .tx_cpl_tlp_valid(tx_cpl_tlp_valid),
    .tx_cpl_tlp_sop(tx_cpl_tlp_sop), .tx_cpl_tlp_eop(tx_cpl_tlp_eop),
    .tx_cpl_tlp_ready(tx_cpl_tlp_ready),
    .grant_id(grant_id), .proto_err(proto_err), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input logic [7:0] tag, input int beat);
    return {8{tag, 8'(beat), 16'hC0DE}};
  endfunction

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_src();
    s0_tlp_data = '0; s0_tlp_strb = '0; s0_tlp_hdr = '0;
    s0_tlp_valid = 0; s0_tlp_sop = 0; s0_tlp_eop = 0;
    s1_tlp_data = '0; s1_tlp_strb = '0; s1_tlp_hdr = '0;
    s1_tlp_valid = 0; s1_tlp_sop = 0; s1_tlp_eop = 0;
  endtask

  task automatic drv0(input logic [7:0] tag, input int b, input logic sop, input logic eop);
    s0_tlp_data = pat(tag, b); s0_tlp_strb = 8'hFF; s0_tlp_hdr = {16{8'hA5}};
    s0_tlp_valid = 1; s0_tlp_sop = sop; s0_tlp_eop = eop;
  endtask

  task automatic drv1(input logic [7:0] tag, input int b, input logic sop, input logic eop);
    s1_tlp_data = pat(tag, b); s1_tlp_strb = 8'h0F; s1_tlp_hdr = {16{8'h5A}};
    s1_tlp_valid = 1; s1_tlp_sop = sop; s1_tlp_eop = eop;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    clr_src(); tx_cpl_tlp_ready = 1;
    rst = 1; tick(); tick(); rst = 0; #1;
    total++; if (tx_cpl_tlp_valid !== 0 || tx_cpl_tlp_sop !== 0 || tx_cpl_tlp_eop !== 0)
      $display("FAIL reset_qual: got v/s/e %b%b%b expected 000", tx_cpl_tlp_valid, tx_cpl_tlp_sop, tx_cpl_tlp_eop); else passed++;
    total++; if (tx_cpl_tlp_data !== '0 || tx_cpl_tlp_hdr !== '0 || tx_cpl_tlp_strb !== '0)
      $display("FAIL reset_fields: got data %h hdr %h expected 0", tx_cpl_tlp_data, tx_cpl_tlp_hdr); else passed++;
    total++; if ({s0_tlp_ready, s1_tlp_ready, grant_id, proto_err} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b expected 0000", {s0_tlp_ready, s1_tlp_ready, grant_id, proto_err}); else passed++;
    total++; if (pkt_cnt0 !== 16'd0 || pkt_cnt1 !== 16'd0)
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0", pkt_cnt0, pkt_cnt1); else passed++;
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      drv0(8'hA5, i, i == 0, i == 2); #1;
      total++; if (s0_tlp_ready !== 1'b1) $display("FAIL single_rdy%0d: got %b expected 1", i, s0_tlp_ready); else passed++;
      tick();
      total++; if (tx_cpl_tlp_valid !== 1 || tx_cpl_tlp_data !== pat(8'hA5, i) || tx_cpl_tlp_hdr !== {16{8'hA5}} ||
                   tx_cpl_tlp_strb !== 8'hFF || tx_cpl_tlp_sop !== (i == 0) || tx_cpl_tlp_eop !== (i == 2))
        $display("FAIL single_beat%0d: got v%b s%b e%b data %h expected data %h", i, tx_cpl_tlp_valid,
                 tx_cpl_tlp_sop, tx_cpl_tlp_eop, tx_cpl_tlp_data, pat(8'hA5, i)); else passed++;
      if (i < 2) begin
        total++; if (grant_id !== 1'b0) $display("FAIL single_grant%0d: got %b expected 0", i, grant_id); else passed++;
      end
    end
    clr_src(); tick();
    total++; if (tx_cpl_tlp_valid !== 0) $display("FAIL single_idle: got valid %b expected 0", tx_cpl_tlp_valid); else passed++;
    total++; if (pkt_cnt0 !== 16'd1) $display("FAIL single_cnt0: got %0d expected 1", pkt_cnt0); else passed++;
  endtask

  task automatic test_contention();
    clr_src(); do_reset();
    drv0(8'h10, 0, 1, 0); drv1(8'h20, 0, 1, 1); #1;
    total++; if ({s0_tlp_ready, s1_tlp_ready} !== 2'b10) $display("FAIL cont_rdy0: got %b expected 10", {s0_tlp_ready, s1_tlp_ready}); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h10, 0) || tx_cpl_tlp_sop !== 1) $display("FAIL cont_b0: got %h expected %h", tx_cpl_tlp_data, pat(8'h10, 0)); else passed++;
    drv0(8'h10, 1, 0, 1); #1;
    total++; if ({s0_tlp_ready, s1_tlp_ready} !== 2'b10) $display("FAIL cont_rdy1: got %b expected 10", {s0_tlp_ready, s1_tlp_ready}); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h10, 1) || tx_cpl_tlp_eop !== 1) $display("FAIL cont_b1: got %h expected %h", tx_cpl_tlp_data, pat(8'h10, 1)); else passed++;
    s0_tlp_valid = 0; #1;
    total++; if (s1_tlp_ready !== 1) $display("FAIL cont_rdy2: got %b expected 1", s1_tlp_ready); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h20, 0) || tx_cpl_tlp_sop !== 1 || tx_cpl_tlp_eop !== 1 || tx_cpl_tlp_hdr !== {16{8'h5A}})
      $display("FAIL cont_s1: got %h expected %h", tx_cpl_tlp_data, pat(8'h20, 0)); else passed++;
    // rr pointer is back on source 0: a fresh tie goes to s0.
    drv0(8'h11, 0, 1, 1); drv1(8'h21, 0, 1, 1); #1;
    total++; if ({s0_tlp_ready, s1_tlp_ready} !== 2'b10) $display("FAIL cont_rr_end: got %b expected 10", {s0_tlp_ready, s1_tlp_ready}); else passed++;
    clr_src(); tick();
  endtask

  task automatic test_round_robin();
    clr_src(); do_reset();
    drv0(8'h30, 0, 1, 1); drv1(8'h40, 0, 1, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (tx_cpl_tlp_data !== ((i % 2 == 0) ? pat(8'h30, 0) : pat(8'h40, 0)))
        $display("FAIL rr_pkt%0d: got %h expected source %0d", i, tx_cpl_tlp_data, i % 2); else passed++;
    end
    clr_src(); tick();
    total++; if (pkt_cnt0 !== 16'd4 || pkt_cnt1 !== 16'd4) $display("FAIL rr_cnt: got %0d/%0d expected 4/4", pkt_cnt0, pkt_cnt1); else passed++;
  endtask

  task automatic test_backpressure();
    clr_src(); do_reset();
    drv1(8'h50, 0, 1, 0); tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h50, 0)) $display("FAIL bp_b0: got %h expected %h", tx_cpl_tlp_data, pat(8'h50, 0)); else passed++;
    drv0(8'h60, 0, 1, 1); drv1(8'h50, 1, 0, 0); #1;
    total++; if ({s0_tlp_ready, s1_tlp_ready} !== 2'b01) $display("FAIL bp_lock: got %b expected 01", {s0_tlp_ready, s1_tlp_ready}); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h50, 1)) $display("FAIL bp_b1: got %h expected %h", tx_cpl_tlp_data, pat(8'h50, 1)); else passed++;
    tx_cpl_tlp_ready = 0; drv1(8'h50, 2, 0, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      total++; if (tx_cpl_tlp_valid !== 1 || tx_cpl_tlp_data !== pat(8'h50, 1) || s1_tlp_ready !== 0 || s0_tlp_ready !== 0)
        $display("FAIL bp_hold%0d: got v%b rdy %b%b data %h expected held %h", k, tx_cpl_tlp_valid,
                 s0_tlp_ready, s1_tlp_ready, tx_cpl_tlp_data, pat(8'h50, 1)); else passed++;
    end
    tx_cpl_tlp_ready = 1; tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h50, 2)) $display("FAIL bp_b2: got %h expected %h", tx_cpl_tlp_data, pat(8'h50, 2)); else passed++;
    drv1(8'h50, 3, 0, 1); tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h50, 3) || tx_cpl_tlp_eop !== 1) $display("FAIL bp_b3: got %h expected %h", tx_cpl_tlp_data, pat(8'h50, 3)); else passed++;
    s1_tlp_valid = 0; #1;
    total++; if (s0_tlp_ready !== 1) $display("FAIL bp_s0_rdy: got %b expected 1", s0_tlp_ready); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h60, 0)) $display("FAIL bp_s0: got %h expected %h", tx_cpl_tlp_data, pat(8'h60, 0)); else passed++;
    clr_src(); tick();
    total++; if (pkt_cnt0 !== 16'd1 || pkt_cnt1 !== 16'd1) $display("FAIL bp_cnt: got %0d/%0d expected 1/1", pkt_cnt0, pkt_cnt1); else passed++;
  endtask

  task automatic test_proto_err();
    clr_src(); do_reset();
    drv0(8'h70, 0, 0, 0); #1;
    total++; if (s0_tlp_ready !== 1) $display("FAIL perr_rdy: got %b expected 1", s0_tlp_ready); else passed++;
    tick();
    total++; if (proto_err !== 1 || tx_cpl_tlp_valid !== 0) $display("FAIL perr_pulse: got err %b valid %b expected 1 0", proto_err, tx_cpl_tlp_valid); else passed++;
    clr_src(); tick();
    total++; if (proto_err !== 0 || tx_cpl_tlp_valid !== 0 || pkt_cnt0 !== 0) $display("FAIL perr_end: got err %b valid %b cnt %0d expected 0 0 0", proto_err, tx_cpl_tlp_valid, pkt_cnt0); else passed++;
  endtask

  task automatic test_reset_mid();
    clr_src(); do_reset();
    drv0(8'h80, 0, 1, 0); tick();
    drv0(8'h80, 1, 0, 0); tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h80, 1)) $display("FAIL rmid_b1: got %h expected %h", tx_cpl_tlp_data, pat(8'h80, 1)); else passed++;
    clr_src(); rst = 1; tick(); rst = 0;
    total++; if (tx_cpl_tlp_valid !== 0 || tx_cpl_tlp_data !== '0 || grant_id !== 0 || pkt_cnt0 !== 0)
      $display("FAIL rmid_clear: got valid %b data %h grant %b cnt %0d expected all 0", tx_cpl_tlp_valid, tx_cpl_tlp_data, grant_id, pkt_cnt0); else passed++;
    drv1(8'h90, 0, 1, 1); #1;
    total++; if (s1_tlp_ready !== 1) $display("FAIL rmid_s1_rdy: got %b expected 1", s1_tlp_ready); else passed++;
    tick();
    total++; if (tx_cpl_tlp_data !== pat(8'h90, 0) || tx_cpl_tlp_valid !== 1) $display("FAIL rmid_s1: got %h expected %h", tx_cpl_tlp_data, pat(8'h90, 0)); else passed++;
    clr_src(); tick();
  endtask

  initial begin
    rst = 1; tx_cpl_tlp_ready = 1; clr_src();
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_backpressure();
    test_proto_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpl_tlp_tx_arbiter.md
Name: cpl_tlp_tx_arbiter

Overview:
- Shares the single completion TLP transmit port (tx_cpl_tlp_*) between two completion sources.
  - Source 0: the AXI-master bridge's read-completion generator.
  - Source 1: the CXL.io MCTP response engine.
- Arbitration is round-robin, at TLP-packet granularity. A grant is held from SOP through EOP, so TLPs never interleave.
- The output passes through one registered pipeline stage.
- Sits between the completion generators and the PCIe/CXL transaction-layer TX interface.

Parameters:
- TLP_DATA_WIDTH, 256, payload bits per beat.
- TLP_STRB_WIDTH, 8, dword enables per beat (TLP_DATA_WIDTH/32).
- TLP_HDR_WIDTH, 128, TLP header bits (valid on SOP beat).

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- s0_tlp_data  in  TLP_DATA_WIDTH  source 0 payload.
- s0_tlp_strb  in  TLP_STRB_WIDTH  source 0 dword enables.
- s0_tlp_hdr  in  TLP_HDR_WIDTH  source 0 header.
- s0_tlp_valid/s0_tlp_sop/s0_tlp_eop  in  1 each  source 0 beat qualifiers.
- s0_tlp_ready  out  1  source 0 beat accepted.
- s1_tlp_data/strb/hdr/valid/sop/eop  in  as s0  source 1 stream.
- s1_tlp_ready  out  1  source 1 beat accepted.
- tx_cpl_tlp_data  out  TLP_DATA_WIDTH  arbitrated payload.
- tx_cpl_tlp_strb  out  TLP_STRB_WIDTH  arbitrated dword enables.
- tx_cpl_tlp_hdr  out  TLP_HDR_WIDTH  arbitrated header.
- tx_cpl_tlp_valid/tx_cpl_tlp_sop/tx_cpl_tlp_eop  out  1 each  output qualifiers.
- tx_cpl_tlp_ready  in  1  sink accepts output beat.
- grant_id  out  1  source currently owning the port (debug/monitor).
- proto_err  out  1  one-cycle pulse: a beat with valid=1, sop=0 was dropped in IDLE.
- pkt_cnt0, pkt_cnt1  out  16 each  completed-TLP counters per source.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - State IDLE; rr_ptr=0 (source 0 has priority first).
  - Output register empty: tx_cpl_tlp_valid/sop/eop=0; data/strb/hdr=0.
  - s0/s1_tlp_ready=0, grant_id=0, proto_err=0, pkt_cnt0/1=0.
- Output stage is a single register:
  - slot_free = !tx_cpl_tlp_valid || tx_cpl_tlp_ready (combinational).
  - An accepted source beat appears on tx_cpl_tlp_* the next cycle: latency 1.
  - Output fields hold stable while tx_cpl_tlp_valid=1 and tx_cpl_tlp_ready=0.
- Handshake:
  - sN_tlp_ready = slot_free && (source N eligible in the current state).
  - A beat is accepted when sN_tlp_valid && sN_tlp_ready.
  - Sources hold their beat until accepted (AXI-stream rules).
- FSM states: IDLE, LOCK0, LOCK1.
  - IDLE, eligibility:
    - A source is eligible if valid && sop.
    - If both are eligible, the one selected by rr_ptr wins.
    - Only the winner sees ready.
  - IDLE, on accept with eop=0: go to LOCKn and set grant_id=n.
  - IDLE, on accept with eop=1 (single-beat TLP): stay in IDLE; set rr_ptr=!n; increment pkt_cntn.
  - IDLE, if slot_free=0: no acceptance and no state change.
  - LOCKn: only source n is eligible, whatever its sop value.
  - LOCKn, on accepted eop: return to IDLE; set rr_ptr=!n; increment pkt_cntn.
  - LOCKn, sop=1 on a non-first beat: forwarded unchanged. No check is made.
- Protocol error:
  - In IDLE with slot_free=1, a source with valid=1 and sop=0 is given ready=1 and its beat is discarded.
  - This takes priority over arbitration for that source only.
  - proto_err pulses for 1 cycle; it pulses once even if both sources are in error.
- Fairness:
  - rr_ptr changes only at packet completion.
  - A continuously requesting opposite source wins the next arbitration.
  - No source waits more than one packet.
- Counters wrap modulo 2^16.
- Reset mid-packet: FSM returns to IDLE and the output register clears. A partial TLP is truncated; the sink must also be reset.
- The sink may hold tx_cpl_tlp_ready=0 indefinitely. Both sources then stall with no loss and no reordering.

Decomposition:
- Shared package cpl_arb_pkg:
  - state enum arb_state_e {IDLE, LOCK0, LOCK1};
  - source-index localparams SRC_AXI=0, SRC_MCTP=1;
  - beat struct tlp_beat_t {data, strb, hdr, sop, eop}.
- One natural sub-module: tlp_pipe_reg, the single-entry valid/ready output register holding tlp_beat_t.

Test Plan:
- Single source: s0 sends a 3-beat TLP (hdr=0xA5…, sop on beat 0, eop on beat 2), sink always ready.
  - Expect an identical 3-beat TLP on tx_cpl 1 cycle later each beat; pkt_cnt0=1; grant_id=0 during the packet.
- Contention: both sources assert sop the same cycle after reset; s0 sends 2 beats, s1 sends 1 beat.
  - Expect order s0 b0, s0 b1, then s1 b0; s1_tlp_ready=0 until s0 eop accepted; rr_ptr ends at 0.
- Round-robin: both sources stream back-to-back single-beat TLPs for 8 packets.
  - Expect strict alternation 0,1,0,1…; pkt_cnt0=4, pkt_cnt1=4.
- Backpressure: tx_cpl_tlp_ready=0 for 5 cycles in the middle of a 4-beat s1 TLP.
  - Expect output beat held stable, s1_tlp_ready=0 throughout, no s0 beat interleaved, all 4 beats delivered in order.
- Protocol error: s0 valid=1, sop=0 while in IDLE.
  - Expect beat dropped, proto_err=1 for exactly 1 cycle, tx_cpl_tlp_valid remains 0.
- Reset mid-packet: rst=1 after beat 1 of a 3-beat s0 TLP.
  - Expect all outputs 0 next cycle; then a new s1 sop is granted first (rr_ptr=0 but s0 idle).
